mmio_button_in: RTL and testbench

//  Memory-mapped input port: CPU reads debounced push-buttons/switches over the data bus.

---
 rtl/soc_mmio_pkg.sv | 20 ++
 rtl/debounce_bit.sv | 49 ++++
 rtl/mmio_button_in.sv | 97 +++++++++
 tb/tb_mmio_button_in.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_mmio_pkg.sv
// Shared MMIO address map: block base addresses and register offsets within a 16-byte window.
// Pure declarations; no latency or backpressure.
package soc_mmio_pkg;

  localparam logic [31:0] LED_BASE    = 32'hFFFF_0000;
  localparam logic [31:0] BUTTON_BASE = 32'hFFFF_0010;

  // Word offset inside a block window, i.e. addr[3:2].
  typedef enum logic [1:0] {
    OFF_LEVEL = 2'd0,
    OFF_RISE  = 2'd1,
    OFF_FALL  = 2'd2,
    OFF_IRQEN = 2'd3
  } mmio_off_e;

  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input: 2-FF synchroniser, optional inversion, stability counter and debounced level.
// Level follows the pad 2 + DB_CYCLES cycles after a clean change; no backpressure.
module debounce_bit #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter bit          INV       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic level_next
);

  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic          synced;
  logic [CW-1:0] cnt;
  logic          done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], pin};
    end
  end

  assign synced     = sync[1] ^ INV;
  assign done       = (synced != level) && (cnt == CNT_MAX);
  assign level_next = done ? synced : level;

  // Counter only runs while the synced input disagrees, so it never passes CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      level <= level_next;
      if (synced == level || done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_button_in.sv
// Memory-mapped debounced button port: LEVEL, W1C RISE/FALL edge flags, IRQEN and a level irq.
// rdata is combinational (same-cycle load); irq registered from next-state flags; no backpressure.
module mmio_button_in
  import soc_mmio_pkg::*;
#(
  parameter int unsigned     N_IN      = 8,
  parameter logic [31:0]     BASE_ADDR = BUTTON_BASE,
  parameter int unsigned     DB_CYCLES = 500000,
  parameter logic [N_IN-1:0] INV_MASK  = {N_IN{1'b1}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] pin_in,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            we,
  input  logic [3:0]      strobe,
  output logic [31:0]     rdata,
  output logic            irq
);

  logic [N_IN-1:0] level, level_next;
  logic [N_IN-1:0] rise_q, fall_q, irq_en_q;
  logic [N_IN-1:0] rise_d, fall_d, irq_en_d;
  logic [N_IN-1:0] rise_clr, fall_clr;
  logic [N_IN-1:0] lane_mask, wmask;
  logic            sel, wr;
  mmio_off_e       offset;
  logic            unused_bits;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    debounce_bit #(
      .DB_CYCLES(DB_CYCLES),
      .INV      (INV_MASK[i])
    ) u_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .pin       (pin_in[i]),
      .level     (level[i]),
      .level_next(level_next[i])
    );
    assign lane_mask[i] = strobe[i/8];
  end

  assign sel    = in_window(addr, BASE_ADDR);
  assign offset = mmio_off_e'(addr[3:2]);
  assign wr     = we && sel;
  assign wmask  = wdata[N_IN-1:0] & lane_mask;

  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    irq_en_d = irq_en_q;
    if (wr) begin
      case (offset)
        OFF_RISE:  rise_clr = wmask;
        OFF_FALL:  fall_clr = wmask;
        OFF_IRQEN: irq_en_d = (irq_en_q & ~lane_mask) | wmask;
        default:   ;
      endcase
    end
  end

  // New edges are OR-ed in after the clear, so a same-cycle set survives.
  assign rise_d = (rise_q & ~rise_clr) | (level_next & ~level);
  assign fall_d = (fall_q & ~fall_clr) | (~level_next & level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
      irq      <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
      irq      <= |((rise_d | fall_d) & irq_en_d);
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        OFF_LEVEL: rdata[N_IN-1:0] = level;
        OFF_RISE:  rdata[N_IN-1:0] = rise_q;
        OFF_FALL:  rdata[N_IN-1:0] = fall_q;
        OFF_IRQEN: rdata[N_IN-1:0] = irq_en_q;
        default:   rdata = '0;
      endcase
    end
  end

  assign unused_bits = ^{addr[1:0], wdata, strobe};

endmodule

// File: tb/tb_mmio_button_in.sv
// Bench for mmio_button_in (N_IN=8, DB_CYCLES=4, INV_MASK=0): directed scenarios plus a
// randomized run against a window-based behavioural model.
module tb_mmio_button_in;

  localparam logic [31:0] BASE = 32'hFFFF_0010;
  localparam logic [31:0] LED  = 32'hFFFF_0000;

  logic        clk, rst_n;
  logic [7:0]  pin_in;
  logic [31:0] addr, wdata, rdata;
  logic        we, irq;
  logic [3:0]  strobe;

  int errors = 0;
  int checks = 0;

  mmio_button_in #(.N_IN(8), .DB_CYCLES(4), .INV_MASK(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .addr(addr), .wdata(wdata),
    .we(we), .strobe(strobe), .rdata(rdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: level takes value v once the last 4 synchronised samples all equal v.
  logic [7:0] m_s0, m_s1, m_win[3];
  logic [7:0] m_lvl, m_rise, m_fall, m_ien;
  logic       m_irq;
  logic [7:0] m_syn, m_all1, m_all0, m_nl, m_wm, m_rise_n, m_fall_n, m_ien_n;
  logic       m_wr, m_irq_n;

  always_comb begin
    m_syn    = m_s1;
    m_all1   = m_syn & m_win[0] & m_win[1] & m_win[2];
    m_all0   = ~(m_syn | m_win[0] | m_win[1] | m_win[2]);
    m_nl     = (m_lvl | m_all1) & ~m_all0;
    m_wr     = we && (addr[31:4] == BASE[31:4]);
    m_wm     = strobe[0] ? wdata[7:0] : 8'h00;
    m_rise_n = (m_rise & ~((m_wr && addr[3:2] == 2'd1) ? m_wm : 8'h00)) | (m_nl & ~m_lvl);
    m_fall_n = (m_fall & ~((m_wr && addr[3:2] == 2'd2) ? m_wm : 8'h00)) | (~m_nl & m_lvl);
    m_ien_n  = (m_wr && addr[3:2] == 2'd3 && strobe[0]) ? wdata[7:0] : m_ien;
    m_irq_n  = |((m_rise_n | m_fall_n) & m_ien_n);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s0 <= 8'h00; m_s1 <= 8'h00;
      m_win[0] <= 8'h00; m_win[1] <= 8'h00; m_win[2] <= 8'h00;
      m_lvl <= 8'h00; m_rise <= 8'h00; m_fall <= 8'h00; m_ien <= 8'h00; m_irq <= 1'b0;
    end else begin
      m_s0 <= pin_in; m_s1 <= m_s0;
      m_win[0] <= m_syn; m_win[1] <= m_win[0]; m_win[2] <= m_win[1];
      m_lvl <= m_nl; m_rise <= m_rise_n; m_fall <= m_fall_n; m_ien <= m_ien_n; m_irq <= m_irq_n;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; strobe = s; we = 1'b1;
    step();
    we = 1'b0; wdata = 32'h0; strobe = 4'h0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0; pin_in = 8'hFF;
    repeat (3) step();
    rd(BASE + 0, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_level got=%h exp=%h", v, 32'h0); end
    rd(BASE + 4, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_rise got=%h exp=%h", v, 32'h0); end
    rd(BASE + 8, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_fall got=%h exp=%h", v, 32'h0); end
    rd(BASE + 12, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_irqen got=%h exp=%h", v, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rst_n = 1'b1;
    repeat (5) step();
    rd(BASE + 0, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL level_early got=%h exp=%h", v, 32'h0); end
    step();
    rd(BASE + 0, v);  checks++; if (v !== 32'hFF) begin errors++; $display("FAIL level_6cyc got=%h exp=%h", v, 32'hFF); end
    rd(BASE + 4, v);  checks++; if (v !== 32'hFF) begin errors++; $display("FAIL rise_6cyc got=%h exp=%h", v, 32'hFF); end
    rd(BASE + 8, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL fall_6cyc got=%h exp=%h", v, 32'h0); end
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    wr(BASE + 4, 32'hFF, 4'b0001);
    rd(BASE + 4, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL rise_clear_all got=%h exp=%h", v, 32'h0); end
    pin_in = 8'h00;
    repeat (8) step();
    rd(BASE + 0, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL level_low got=%h exp=%h", v, 32'h0); end
    rd(BASE + 8, v); checks++; if (v !== 32'hFF) begin errors++; $display("FAIL fall_all got=%h exp=%h", v, 32'hFF); end
    wr(BASE + 8, 32'hFF, 4'b0001);
    pin_in = 8'h01;
    repeat (3) step();
    pin_in = 8'h00;
    repeat (8) step();
    rd(BASE + 0, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL glitch_level got=%h exp=%h", v, 32'h0); end
    rd(BASE + 4, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL glitch_rise got=%h exp=%h", v, 32'h0); end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    wr(BASE + 12, 32'h1, 4'b1111);
    rd(BASE + 12, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL irqen_wr got=%h exp=%h", v, 32'h1); end
    pin_in = 8'h01;
    repeat (5) step();
    rd(BASE + 0, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL irq_level_early got=%h exp=%h", v, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq); end
    step();
    rd(BASE + 0, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL irq_level got=%h exp=%h", v, 32'h1); end
    rd(BASE + 4, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL irq_rise got=%h exp=%h", v, 32'h1); end
    step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got=%b exp=1", irq); end
  endtask

  task automatic test_w1c();
    logic [31:0] v;
    wr(BASE + 4, 32'h1, 4'b0000);
    rd(BASE + 4, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL w1c_nostrobe got=%h exp=%h", v, 32'h1); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_nostrobe_irq got=%b exp=1", irq); end
    wr(BASE + 4, 32'h1, 4'b0001);
    rd(BASE + 4, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL w1c_clear got=%h exp=%h", v, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got=%b exp=0", irq); end
  endtask

  task automatic test_set_wins();
    logic [31:0] v;
    pin_in = 8'h00;
    repeat (8) step();
    wr(BASE + 8, 32'h1, 4'b0001);
    pin_in = 8'h01;
    repeat (5) step();
    rd(BASE + 0, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL setwin_pre_level got=%h exp=%h", v, 32'h0); end
    wr(BASE + 4, 32'h1, 4'b0001);
    rd(BASE + 4, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL setwin_rise got=%h exp=%h", v, 32'h1); end
    rd(BASE + 0, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL setwin_level got=%h exp=%h", v, 32'h1); end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    rd(LED, v);       checks++; if (v !== 32'h0) begin errors++; $display("FAIL dec_led got=%h exp=%h", v, 32'h0); end
    rd(BASE + 16, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL dec_above got=%h exp=%h", v, 32'h0); end
    wr(BASE + 0, 32'h0, 4'b1111);
    rd(BASE + 0, v);  checks++; if (v !== 32'h1) begin errors++; $display("FAIL dec_level_ro got=%h exp=%h", v, 32'h1); end
    wr(BASE + 12, 32'hFF, 4'b1110);
    rd(BASE + 12, v); checks++; if (v !== 32'h1) begin errors++; $display("FAIL dec_irqen_lane got=%h exp=%h", v, 32'h1); end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] a;
    int          o;
    for (int n = 0; n < 400; n++) begin
      rd(BASE + 0, v);  checks++; if (v !== {24'h0, m_lvl})  begin errors++; $display("FAIL rnd_level n=%0d got=%h exp=%h", n, v, m_lvl); end
      rd(BASE + 4, v);  checks++; if (v !== {24'h0, m_rise}) begin errors++; $display("FAIL rnd_rise n=%0d got=%h exp=%h", n, v, m_rise); end
      rd(BASE + 8, v);  checks++; if (v !== {24'h0, m_fall}) begin errors++; $display("FAIL rnd_fall n=%0d got=%h exp=%h", n, v, m_fall); end
      rd(BASE + 12, v); checks++; if (v !== {24'h0, m_ien})  begin errors++; $display("FAIL rnd_irqen n=%0d got=%h exp=%h", n, v, m_ien); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, irq, m_irq); end
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) pin_in[b] = ~pin_in[b];
      end
      if ($urandom_range(0, 4) == 0) begin
        o = $urandom_range(0, 4);
        a = (o == 4) ? LED : BASE + 32'(o * 4);
        wr(a, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    pin_in = 8'h00;
    repeat (10) step();
    wr(BASE + 12, 32'hFF, 4'b0001);
    pin_in = 8'hFF;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    rd(BASE + 0, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_level got=%h exp=%h", v, 32'h0); end
    rd(BASE + 4, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_rise got=%h exp=%h", v, 32'h0); end
    rd(BASE + 8, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_fall got=%h exp=%h", v, 32'h0); end
    rd(BASE + 12, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_irqen got=%h exp=%h", v, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got=%b exp=0", irq); end
    step();
    rst_n = 1'b1;
    repeat (5) step();
    rd(BASE + 0, v);  checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_relevel_early got=%h exp=%h", v, 32'h0); end
    step();
    rd(BASE + 0, v);  checks++; if (v !== 32'hFF) begin errors++; $display("FAIL mid_relevel got=%h exp=%h", v, 32'hFF); end
    rd(BASE + 4, v);  checks++; if (v !== 32'hFF) begin errors++; $display("FAIL mid_rerise got=%h exp=%h", v, 32'hFF); end
  endtask

  initial begin
    rst_n = 1'b0; pin_in = 8'h00; addr = 32'h0; wdata = 32'h0; we = 1'b0; strobe = 4'h0;
    test_reset();
    test_glitch();
    test_irq();
    test_w1c();
    test_set_wins();
    test_decode();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
